// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master round-robin arbiter in front of the biu data port.
//   Master 0 is the CPU data port, master 1 a secondary bus master (display/DMA).
//   One master owns the bus at a time; ownership is bounded to MAX_HOLD cycles
//   while the other master is waiting. The owner's address, write data and byte
//   enables are muxed onto daddr/dwdata/dwe; read data is captured and returned
//   with a one-cycle rvalid pulse to the master that issued the read.
// Ports:
//   clk, reset (synchronous, active-low)
//   m0_req/m0_addr/m0_wdata/m0_we -> m0_gnt/m0_rdata/m0_rvalid   (master 0)
//   m1_req/m1_addr/m1_wdata/m1_we -> m1_gnt/m1_rdata/m1_rvalid   (master 1)
//   daddr/dwdata/dwe              -> biu request (combinational from state)
//   drdata                        <- biu read data (combinational read path)
// Optional: define ARB_STATS_EN to add stat_g0/stat_g1/stat_ct counters.
module dbus_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_we,
    output logic        m0_gnt,
    output logic [31:0] m0_rdata,
    output logic        m0_rvalid,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_we,
    output logic        m1_gnt,
    output logic [31:0] m1_rdata,
    output logic        m1_rvalid,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwe,
    input  logic [31:0] drdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0] stat_g0,
    output logic [15:0] stat_g1,
    output logic [15:0] stat_ct
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_TOP = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nxt;
    logic             last, last_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic             hold_top;

    assign hold_top = (hold_cnt == HOLD_TOP);

    // Next-state: round-robin on ties, release hand-over without bubble, forced switch at hold limit
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        hold_nxt  = hold_cnt;
        unique case (state)
            IDLE: begin
                if (m0_req && m1_req) state_nxt = last ? OWN0 : OWN1;
                else if (m0_req)      state_nxt = OWN0;
                else if (m1_req)      state_nxt = OWN1;
            end
            OWN0: begin
                if (!m0_req) begin
                    last_nxt  = 1'b0;
                    state_nxt = m1_req ? OWN1 : IDLE;
                end else if (hold_top && m1_req) begin
                    last_nxt  = 1'b0;
                    state_nxt = OWN1;
                end
            end
            OWN1: begin
                if (!m1_req) begin
                    last_nxt  = 1'b1;
                    state_nxt = m0_req ? OWN0 : IDLE;
                end else if (hold_top && m0_req) begin
                    last_nxt  = 1'b1;
                    state_nxt = OWN0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Hold counter restarts on any ownership change and saturates at the limit
        if (state_nxt != state)                 hold_nxt = '0;
        else if (state != IDLE && !hold_top)    hold_nxt = hold_cnt + CNT_W'(1);
    end

    // State, grant and read-return registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            hold_cnt  <= '0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            hold_cnt  <= hold_nxt;
            m0_gnt    <= (state_nxt == OWN0);
            m1_gnt    <= (state_nxt == OWN1);
            m0_rvalid <= (state == OWN0) && (m0_we == 4'b0000);
            m1_rvalid <= (state == OWN1) && (m1_we == 4'b0000);
            if ((state == OWN0) && (m0_we == 4'b0000)) m0_rdata <= drdata;
            if ((state == OWN1) && (m1_we == 4'b0000)) m1_rdata <= drdata;
        end
    end

    // Bus mux; IDLE drives zeros so no write can escape without a grant
    always_comb begin
        daddr  = '0;
        dwdata = '0;
        dwe    = '0;
        unique case (state)
            OWN0: begin
                daddr  = m0_addr;
                dwdata = m0_wdata;
                dwe    = m0_we;
            end
            OWN1: begin
                daddr  = m1_addr;
                dwdata = m1_wdata;
                dwe    = m1_we;
            end
            default: ;
        endcase
    end

`ifdef ARB_STATS_EN
    // Grant counters saturate; contention counter wraps
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_g0 <= '0;
            stat_g1 <= '0;
            stat_ct <= '0;
        end else begin
            if (state_nxt == OWN0 && state != OWN0 && stat_g0 != 16'hFFFF)
                stat_g0 <= stat_g0 + 16'd1;
            if (state_nxt == OWN1 && state != OWN1 && stat_g1 != 16'hFFFF)
                stat_g1 <= stat_g1 + 16'd1;
            if (m0_req && m1_req)
                stat_ct <= stat_ct + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: randomized bench for dbus_arbiter against a cycle-level
// ownership model (owner / last-granted / cycles-owned bookkeeping).
module tb_dbus_arbiter;

    localparam int unsigned MAX_HOLD = 16;
    localparam int          NCYC     = 6000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  we    [2];
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] daddr, dwdata, drdata;
    logic [3:0]  dwe;
`ifdef ARB_STATS_EN
    logic [15:0] stat_g0, stat_g1, stat_ct;
`endif

    always #5 clk = ~clk;

    dbus_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (req[0]),
        .m0_addr  (addr[0]),
        .m0_wdata (wdata[0]),
        .m0_we    (we[0]),
        .m0_gnt   (m0_gnt),
        .m0_rdata (m0_rdata),
        .m0_rvalid(m0_rvalid),
        .m1_req   (req[1]),
        .m1_addr  (addr[1]),
        .m1_wdata (wdata[1]),
        .m1_we    (we[1]),
        .m1_gnt   (m1_gnt),
        .m1_rdata (m1_rdata),
        .m1_rvalid(m1_rvalid),
        .daddr    (daddr),
        .dwdata   (dwdata),
        .dwe      (dwe),
        .drdata   (drdata)
`ifdef ARB_STATS_EN
        ,
        .stat_g0  (stat_g0),
        .stat_g1  (stat_g1),
        .stat_ct  (stat_ct)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: owner -1 = nobody, run = cycles owned so far
    int          owner = -1;
    int          last  = 1;
    int          run   = 0;
    bit          e_rvalid [2];
    logic [31:0] e_rdata  [2];
    bit          granted  [2];
    int          rem      [2];

    task automatic new_access(input int x);
        addr[x]  = $urandom;
        wdata[x] = $urandom;
        we[x]    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
    endtask

    // Advance the model across one rising edge using the inputs present at that edge
    task automatic model_step();
        granted[0] = 1'b0;
        granted[1] = 1'b0;
        if (!reset) begin
            owner = -1; last = 1; run = 0;
            for (int x = 0; x < 2; x++) begin
                e_rvalid[x] = 1'b0;
                e_rdata[x]  = '0;
            end
        end else begin
            for (int x = 0; x < 2; x++) begin
                e_rvalid[x] = (owner == x) && (we[x] == 4'b0000);
                if (e_rvalid[x]) e_rdata[x] = drdata;
            end
            if (owner < 0) begin
                run = 0;
                if (req[0] && req[1]) owner = 1 - last;
                else if (req[0])      owner = 0;
                else if (req[1])      owner = 1;
            end else begin
                int o;
                o = owner;
                granted[o] = 1'b1;
                run++;
                if (!req[o]) begin
                    last  = o;
                    owner = req[1-o] ? 1 - o : -1;
                    run   = 0;
                end else if (req[1-o] && run >= int'(MAX_HOLD)) begin
                    last  = o;
                    owner = 1 - o;
                    run   = 0;
                end
            end
        end
    endtask

    // Masters: consume one access per granted edge, drop req when done, restart randomly
    task automatic drive();
        reset  = ($urandom_range(0, 299) != 0);
        drdata = $urandom;
        for (int x = 0; x < 2; x++) begin
            if (granted[x]) begin
                rem[x]--;
                if (rem[x] <= 0) req[x] = 1'b0;
                else             new_access(x);
            end else if (!req[x] && $urandom_range(0, 3) == 0) begin
                rem[x] = $urandom_range(1, 40);
                req[x] = 1'b1;
                new_access(x);
            end
        end
    endtask

    task automatic check_outputs();
        check("m0_gnt",    32'(m0_gnt),    32'(owner == 0));
        check("m1_gnt",    32'(m1_gnt),    32'(owner == 1));
        check("daddr",     daddr,          (owner < 0) ? 32'h0 : addr[owner]);
        check("dwdata",    dwdata,         (owner < 0) ? 32'h0 : wdata[owner]);
        check("dwe",       32'(dwe),       (owner < 0) ? 32'h0 : 32'(we[owner]));
        check("m0_rvalid", 32'(m0_rvalid), 32'(e_rvalid[0]));
        check("m1_rvalid", 32'(m1_rvalid), 32'(e_rvalid[1]));
        check("m0_rdata",  m0_rdata,       e_rdata[0]);
        check("m1_rdata",  m1_rdata,       e_rdata[1]);
    endtask

    initial begin
        reset  = 1'b0;
        drdata = '0;
        for (int x = 0; x < 2; x++) begin
            req[x] = 1'b0;
            rem[x] = 0;
            addr[x] = '0;
            wdata[x] = '0;
            we[x] = '0;
            e_rvalid[x] = 1'b0;
            e_rdata[x] = '0;
            granted[x] = 1'b0;
        end
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            model_step();
            #1;
            if (c < 2) begin
                reset  = 1'b0;
                drdata = $urandom;
            end else begin
                drive();
            end
            @(negedge clk);
            check_outputs();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
